// File: rtl/stream_source_pkg.sv
// Shared types and default widths for the stream_source block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_source_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    // Burst sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/stream_source_if.sv
// Output stream bundle: data word plus valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: master holds dout/dout_v until the slave raises dout_r.
interface stream_source_if
    import stream_source_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_v;
    logic                  dout_r;

    modport master (output dout, output dout_v, input dout_r);
    modport slave  (input dout, input dout_v, output dout_r);

endinterface

// File: rtl/stream_source_skid.sv
// Two-entry valid/ready output register; head entry drives the output directly from a flop.
// Latency: 1 cycle from in_vld to out_vld when empty.
// Backpressure: no in_rdy; the producer keeps occupancy plus in-flight reads at or below 2.
module stream_skid
    import stream_source_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_dat,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_dat,
    input  logic                  out_rdy,
    output logic [1:0]            occ
);

    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] e0_q, e0_d;
    logic [DATA_WIDTH-1:0] e1_q, e1_d;
    logic                  pop;

    // Valid comes straight from the count flop, never from out_rdy
    assign out_vld = (cnt_q != 2'd0);
    assign out_dat = e0_q;
    assign occ     = cnt_q;
    assign pop     = out_vld && out_rdy;

    // Next entry contents: head is e0, e1 only used when two words are parked
    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        unique case ({in_vld, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = in_dat;
                else               e1_d = in_dat;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = in_dat;
                end else begin
                    e0_d = e1_q;
                    e1_d = in_dat;
                end
            end
            default: ;
        endcase
    end

    // Entry and count registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

endmodule

// File: rtl/stream_source.sv
// Strided burst reader: streams len words from base, base+stride, ... of a local memory.
// Latency: first dout_v two edges after the start edge, then one word per cycle.
// Backpressure: reads issue only while skid occupancy plus in-flight reads stays below 2.
// Optional looping burst mode under STREAM_SOURCE_REPEAT_EN.
module stream_source
    import stream_source_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [ADDR_WIDTH:0]   len,
`ifdef STREAM_SOURCE_REPEAT_EN
    // Named repeat_mode because 'repeat' is a reserved word
    input  logic                  repeat_mode,
`endif
    stream_source_if.master       out_if,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_dat_q;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH:0]   left_q, left_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  done_q, done_d;
`ifdef STREAM_SOURCE_REPEAT_EN
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic                  rep_q, rep_d;
`endif

    logic                  rd_en;
    logic                  pop;
    logic [1:0]            occ;
    logic [1:0]            eff_occ;
    logic                  wrap_again;

    // Local memory: writes land in any state; the read sees pre-write contents
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_dat_q <= mem[addr_q];
    end

    assign pop = out_if.dout_v && out_if.dout_r;

    // Room check counts the word leaving this cycle so a steady stream never bubbles
    assign eff_occ = occ + {1'b0, rd_vld_q} - {1'b0, pop};
    assign rd_en   = (state_q == ISSUE) && (eff_occ < 2'd2);

`ifdef STREAM_SOURCE_REPEAT_EN
    assign wrap_again = rep_q && repeat_mode;
`else
    assign wrap_again = 1'b0;
`endif

    // Sequencer next-state: descriptor capture, address stepping, completion
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        left_d   = left_q;
        rd_vld_d = rd_en;
        done_d   = 1'b0;
`ifdef STREAM_SOURCE_REPEAT_EN
        base_d   = base_q;
        len_d    = len_q;
        rep_d    = rep_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ISSUE;
                        addr_d   = base;
                        stride_d = stride;
                        left_d   = len;
`ifdef STREAM_SOURCE_REPEAT_EN
                        base_d   = base;
                        len_d    = len;
                        rep_d    = repeat_mode;
`endif
                    end
                end
            end
            ISSUE: begin
                if (rd_en) begin
                    addr_d = addr_q + stride_q;
                    left_d = left_q - LEN_ONE;
                    if (left_q == LEN_ONE) begin
                        if (wrap_again) begin
`ifdef STREAM_SOURCE_REPEAT_EN
                            addr_d = base_q;
                            left_d = len_q;
`endif
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                // Last word: nothing in flight and it is the only one parked
                if (pop && !rd_vld_q && (occ == 2'd1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            left_q   <= '0;
            rd_vld_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef STREAM_SOURCE_REPEAT_EN
            base_q   <= '0;
            len_q    <= '0;
            rep_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            left_q   <= left_d;
            rd_vld_q <= rd_vld_d;
            done_q   <= done_d;
`ifdef STREAM_SOURCE_REPEAT_EN
            base_q   <= base_d;
            len_q    <= len_d;
            rep_q    <= rep_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

    stream_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .in_vld  (rd_vld_q),
        .in_dat  (rd_dat_q),
        .out_vld (out_if.dout_v),
        .out_dat (out_if.dout),
        .out_rdy (out_if.dout_r),
        .occ     (occ)
    );

endmodule

// File: tb/tb_stream_source.sv
// Directed bench for stream_source: bursts, wrap, stalls, len=0, busy start, reset, repeat.
// Latency: checks first dout_v two edges after start and done one cycle after last transfer.
// Backpressure: drives dout_r with steady and 1,0,0 patterns and checks stalled data holds.
module tb_stream_source;

    logic        clock;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [4:0]  base;
    logic [4:0]  stride;
    logic [5:0]  len;
`ifdef STREAM_SOURCE_REPEAT_EN
    logic        repeat_mode;
`endif
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] words[$];
    logic [31:0] exp_q[$];
    int          done_cnt;

    stream_source_if #(.DATA_WIDTH(32)) sif ();

    stream_source #(
        .DATA_WIDTH (32),
        .MEM_DEPTH  (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .base        (base),
        .stride      (stride),
        .len         (len),
`ifdef STREAM_SOURCE_REPEAT_EN
        .repeat_mode (repeat_mode),
`endif
        .out_if      (sif),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs the stream for max_cyc cycles, logging transfers and done pulses
    task automatic collect(input int max_cyc, input bit stall, input int drop_c);
        logic        prev_stall;
        logic [31:0] prev_dat;
        words.delete();
        done_cnt   = 0;
        prev_stall = 1'b0;
        prev_dat   = '0;
        for (int c = 0; c < max_cyc; c++) begin
            sif.dout_r = stall ? ((c % 3) == 0) : 1'b1;
`ifdef STREAM_SOURCE_REPEAT_EN
            repeat_mode = (c < drop_c);
`endif
            if (prev_stall) chk("stall_hold", {31'd0, sif.dout_v, sif.dout}, {31'd0, 1'b1, prev_dat});
            if (sif.dout_v && sif.dout_r) words.push_back(sif.dout);
            if (done) done_cnt++;
            prev_stall = sif.dout_v && !sif.dout_r;
            prev_dat   = sif.dout;
            tick();
        end
        if (drop_c < 0) done_cnt = done_cnt;
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_count"}, words.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < words.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), words[i], exp_q[i]);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        start      = 1'b0;
        base       = '0;
        stride     = '0;
        len        = '0;
        sif.dout_r = 1'b0;
`ifdef STREAM_SOURCE_REPEAT_EN
        repeat_mode = 1'b0;
`endif
        tick();
        tick();
        chk("rst_dout",   sif.dout,   32'd0);
        chk("rst_dout_v", sif.dout_v, 1'b0);
        chk("rst_busy",   busy,       1'b0);
        chk("rst_done",   done,       1'b0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_data = 32'(i + 100);
            tick();
        end
        wr_en = 1'b0;

        // Basic burst with exact cycle timing
        sif.dout_r = 1'b1;
        start = 1'b1; base = 5'd0; stride = 5'd1; len = 6'd4;
        tick();
        start = 1'b0;
        chk("t1_busy_e0", busy, 1'b1);
        chk("t1_v_e0", sif.dout_v, 1'b0);
        tick();
        chk("t1_v_e1", sif.dout_v, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t1_v%0d", k), sif.dout_v, 1'b1);
            chk($sformatf("t1_d%0d", k), sif.dout, 32'(100 + k));
            chk($sformatf("t1_busy%0d", k), busy, 1'b1);
            chk($sformatf("t1_done%0d", k), done, 1'b0);
        end
        tick();
        chk("t1_v_end", sif.dout_v, 1'b0);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_done_end", done, 1'b1);
        tick();
        chk("t1_done_clr", done, 1'b0);

        // Address wrap modulo 32
        start = 1'b1; base = 5'd30; stride = 5'd3; len = 6'd3;
        tick();
        start = 1'b0;
        collect(10, 1'b0, 0);
        exp_q = '{32'd130, 32'd101, 32'd104};
        check_words("t2");

        // Stalled stream
        start = 1'b1; base = 5'd0; stride = 5'd1; len = 6'd6;
        tick();
        start = 1'b0;
        collect(30, 1'b1, 0);
        exp_q = '{32'd100, 32'd101, 32'd102, 32'd103, 32'd104, 32'd105};
        check_words("t3");

        // Zero-length burst
        sif.dout_r = 1'b1;
        start = 1'b1; base = 5'd7; stride = 5'd1; len = 6'd0;
        tick();
        start = 1'b0;
        chk("t4_done", done, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_v", sif.dout_v, 1'b0);
        tick();
        chk("t4_done_clr", done, 1'b0);
        chk("t4_v2", sif.dout_v, 1'b0);

        // Start while busy is ignored
        start = 1'b1; base = 5'd0; stride = 5'd1; len = 6'd3;
        tick();
        base = 5'd10; stride = 5'd2; len = 6'd5;
        tick();
        start = 1'b0;
        collect(12, 1'b0, 0);
        exp_q = '{32'd100, 32'd101, 32'd102};
        check_words("t5");

        // Reset mid-burst after two transfers
        start = 1'b1; base = 5'd0; stride = 5'd1; len = 6'd8;
        tick();
        start = 1'b0;
        collect(4, 1'b0, 0);
        chk("t6_pre_xfers", words.size(), 2);
        reset = 1'b1;
        #1;
        chk("t6_rst_dout", sif.dout, 32'd0);
        chk("t6_rst_v", sif.dout_v, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        tick();
        chk("t6_rst_done2", done, 1'b0);
        reset = 1'b0;
        start = 1'b1; base = 5'd5; stride = 5'd1; len = 6'd2;
        tick();
        start = 1'b0;
        chk("t6_busy", busy, 1'b1);
        collect(10, 1'b0, 0);
        exp_q = '{32'd105, 32'd106};
        check_words("t6");

`ifdef STREAM_SOURCE_REPEAT_EN
        // Looping burst, repeat dropped after five reads issue
        repeat_mode = 1'b1;
        start = 1'b1; base = 5'd0; stride = 5'd1; len = 6'd2;
        tick();
        start = 1'b0;
        collect(16, 1'b0, 5);
        exp_q = '{32'd100, 32'd101, 32'd100, 32'd101, 32'd100, 32'd101};
        check_words("t7");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_source.md
STREAM_SOURCE -- requirements
Module: stream_source

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning stream and memory word width.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 32, meaning number of local memory words; it SHALL be a power of two.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 5, meaning log2(MEM_DEPTH).
REQ-004 The block SHALL have port clock, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-006 The block SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_WIDTH) and wr_data (input, DATA_WIDTH), meaning the memory load port.
REQ-007 The block SHALL have port start, input, 1, meaning a one-cycle request to begin a burst.
REQ-008 The block SHALL have ports base (input, ADDR_WIDTH), stride (input, ADDR_WIDTH) and len (input, ADDR_WIDTH+1), meaning burst descriptor fields sampled with start.
REQ-009 The block SHALL have ports dout (output, DATA_WIDTH), dout_v (output, 1) and dout_r (input, 1), meaning the valid/ready output stream.
REQ-010 The block SHALL have ports busy (output, 1) and done (output, 1), meaning burst in progress and a one-cycle completion pulse.

Function
REQ-011 The block SHALL treat a word as transferred on a rising edge where dout_v and dout_r are both high.
REQ-012 The block SHALL hold dout_v high and dout stable until transfer once dout_v is asserted; dout_v SHALL NOT depend combinationally on dout_r.
REQ-013 The block SHALL sample base/stride/len on the edge where start is high and busy is low; start while busy SHALL be ignored.
REQ-014 The block SHALL emit len words from addresses base, base+stride, base+2*stride, ..., each computed modulo MEM_DEPTH (wrap-around by truncation).
REQ-015 The block SHALL implement FSM states IDLE, ISSUE and DRAIN: IDLE->ISSUE on accepted start with len>0; ISSUE->DRAIN when the last read is issued; DRAIN->IDLE when the last word transfers.
REQ-016 The block SHALL, for accepted start with len=0, stay IDLE, emit no data and pulse done on the next edge.
REQ-017 The block SHALL use a one-cycle-latency synchronous memory read and SHALL assert the first dout_v two edges after the start edge.
REQ-018 The block SHALL sustain one transfer per cycle while dout_r is held high, and SHALL issue a read only when skid occupancy plus in-flight reads is below 2.
REQ-019 The block SHALL assert busy from the edge after accepted start through the edge of the last transfer, then deassert it.
REQ-020 The block SHALL pulse done for exactly one cycle following the edge of the last transfer.
REQ-021 The block SHALL apply wr_en writes in any state; a same-cycle read of the written address SHALL return the old data (read-first).

Reset
REQ-022 The block SHALL, on reset, asynchronously force dout=0, dout_v=0, busy=0, done=0, FSM=IDLE, counters and skid buffer empty; memory contents SHALL NOT be cleared.
REQ-023 The block SHALL, on reset asserted mid-burst, abandon the burst without asserting done, and accept a new start on the first edge after reset deasserts.

Configuration
REQ-024 With STREAM_SOURCE_REPEAT_EN defined, the block SHALL have input repeat (1 bit, sampled with start); when set, after the last read issue it SHALL restart at base without gap, stop only when repeat is sampled low at a wrap, and pulse done once at final completion.
REQ-025 Without STREAM_SOURCE_REPEAT_EN, the block SHALL have no repeat port and every burst SHALL be single-pass.

Structure
REQ-026 The shared package SHALL hold the FSM state enum (IDLE, ISSUE, DRAIN) and default width constants.
REQ-027 The block SHALL instantiate one sub-module stream_skid, a two-entry valid/ready output register.

Verification
REQ-028 Load mem[i]=i+100 for i=0..31; start base=0, stride=1, len=4, dout_r=1 -> dout 100,101,102,103 on consecutive cycles, first dout_v 2 edges after start, done one cycle after the 4th transfer.
REQ-029 Start base=30, stride=3, len=3 -> addresses 30,1,4 -> dout 130,101,104.
REQ-030 Start base=0, stride=1, len=6, with dout_r toggling 1,0,0,1,... -> all 6 words in order, none lost or duplicated, dout stable while stalled.
REQ-031 Start len=0 -> no dout_v, done pulses on next edge; start while busy -> ignored, first burst unchanged.
REQ-032 Assert reset mid-burst after 2 transfers -> all outputs 0 immediately, no done; new start with len=2 -> correct 2 words.
REQ-033 With STREAM_SOURCE_REPEAT_EN, start base=0, stride=1, len=2, repeat=1, drop repeat after 5 words -> 100,101,100,101,100,101, then a single done.
